multicycle_control: RTL



---
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: opcode decode, IF/ID/EXE/MEM/WB sequencing, retired-instruction count.
// Outputs are a combinational decode of State/Op; all enables are masked while Reset is high.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [5:0]       Op,
   input  logic             Zero,
   output logic [2:0]       State,
   output logic             PCWre,
   output logic             IRWre,
   output logic [1:0]       PCSrc,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             ExtSel,
   output logic             RegDst,
   output logic             RegWre,
   output logic             WrRegDSrc,
   output logic             MemWr,
   output logic [CNT_W-1:0] InsCount
);

   localparam logic [2:0] S_IF   = 3'b000;
   localparam logic [2:0] S_ID   = 3'b001;
   localparam logic [2:0] S_EXE  = 3'b010;
   localparam logic [2:0] S_MEM  = 3'b011;
   localparam logic [2:0] S_WB   = 3'b100;
   localparam logic [2:0] S_HALT = 3'b111;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_XOR  = 6'b010011;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SRL  = 6'b011001;
   localparam logic [5:0] OP_SLT  = 6'b100100;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   logic [2:0] state, state_nxt;
   logic       run;
   logic       is_r, is_imm, is_lw, is_sw, is_beq, is_j, is_halt;
   logic [2:0] alu_op;

   always_comb begin
      is_r    = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_OR)  || (Op == OP_AND) ||
                (Op == OP_XOR) || (Op == OP_SLL) || (Op == OP_SRL) || (Op == OP_SLT);
      is_imm  = (Op == OP_ADDI) || (Op == OP_ORI);
      is_lw   = (Op == OP_LW);
      is_sw   = (Op == OP_SW);
      is_beq  = (Op == OP_BEQ);
      is_j    = (Op == OP_J);
      is_halt = (Op == OP_HALT);
   end

   always_comb begin
      alu_op = 3'b000;
      case (Op)
         OP_SUB, OP_BEQ: alu_op = 3'b001;
         OP_SLT:         alu_op = 3'b010;
         OP_SRL:         alu_op = 3'b011;
         OP_SLL:         alu_op = 3'b100;
         OP_OR, OP_ORI:  alu_op = 3'b101;
         OP_AND:         alu_op = 3'b110;
         OP_XOR:         alu_op = 3'b111;
         default:        alu_op = 3'b000;
      endcase
   end

   // run holds the FSM in IF until the first full clock after reset release
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= S_IF;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = S_IF;
      if (run) begin
         case (state)
            S_IF:    state_nxt = S_ID;
            S_ID:    state_nxt = is_halt ? S_HALT :
                                 (is_r || is_imm || is_lw || is_sw || is_beq) ? S_EXE : S_IF;
            S_EXE:   state_nxt = is_beq ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:   state_nxt = is_lw ? S_WB : S_IF;
            S_WB:    state_nxt = S_IF;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IF;
         endcase
      end
   end

   always_comb begin
      State     = state;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      PCSrc     = 2'b00;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      ExtSel    = 1'b0;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      MemWr     = 1'b0;
      if (Reset) begin
         State = S_IF;
      end else if (run) begin
         // ALU controls stay stable from EXE through the end of the instruction
         if (state == S_EXE || state == S_MEM || state == S_WB) begin
            ALUOp   = alu_op;
            ALUSrcB = is_imm || is_lw || is_sw;
            ExtSel  = (Op == OP_ADDI) || is_lw || is_sw || is_beq;
         end
         case (state)
            S_IF:  IRWre = 1'b1;
            S_ID: begin
               if (!(is_r || is_imm || is_lw || is_sw || is_beq || is_halt)) begin
                  PCWre = 1'b1;
                  PCSrc = is_j ? 2'b10 : 2'b00;
               end
            end
            S_EXE: begin
               if (is_beq) begin
                  PCWre = 1'b1;
                  PCSrc = Zero ? 2'b01 : 2'b00;
               end
            end
            S_MEM: begin
               MemWr = is_sw;
               PCWre = is_sw;
            end
            S_WB: begin
               RegWre    = 1'b1;
               RegDst    = is_r;
               WrRegDSrc = is_lw;
               PCWre     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         InsCount <= '0;
      else if (PCWre)
         InsCount <= InsCount + 1'b1;
   end

endmodule
